// File: rtl/mem_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bank_ctrl
// Description : Single-port data memory with byte-enabled writes, a
//               valid/ready request channel and a credit-controlled,
//               buffered valid/ready read-response channel. Out-of-range
//               reads return zero data with the error flag set.
//               Optional per-lane even parity is enabled by defining the
//               macro MEM_PARITY_EN (adds the in_mem_par_flip port).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bank_ctrl #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int READ_LAT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  in_mem_req_valid,
  output logic                  out_mem_req_ready,
  input  logic [ADDR_W-1:0]     in_mem_addr,
  input  logic                  in_mem_re_web,
  input  logic [DATA_W-1:0]     in_mem_write_data,
  input  logic [DATA_W/8-1:0]   in_mem_byte_en,
`ifdef MEM_PARITY_EN
  input  logic                  in_mem_par_flip,
`endif
  output logic                  out_mem_resp_valid,
  input  logic                  in_mem_resp_ready,
  output logic [DATA_W-1:0]     out_mem_data,
  output logic                  out_mem_resp_err
);

  localparam int NB         = DATA_W / 8;
  localparam int RESP_DEPTH = READ_LAT + 1;
  localparam int CNT_W      = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W      = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  localparam logic [ADDR_W:0]  DEPTH_EXT  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RESP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(RESP_DEPTH - 1);

  // --------------------------------------------------------------------------
  // Storage and request decode
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              in_range;
  logic              accept;
  logic              rd_acc;
  logic              wr_acc;
  logic              pop;
  logic [DATA_W-1:0] rd_word_raw;
  logic [DATA_W-1:0] rd_word;
  logic              rd_err;

  // Addresses at or above DEPTH exist only when DEPTH is not a power of two.
  assign in_range = ({1'b0, in_mem_addr} < DEPTH_EXT);
  assign accept   = in_mem_req_valid && out_mem_req_ready;
  assign rd_acc   = accept && in_mem_re_web;
  assign wr_acc   = accept && !in_mem_re_web && in_range;
  assign pop      = out_mem_resp_valid && in_mem_resp_ready;

  assign rd_word_raw = mem_q[in_mem_addr];
  assign rd_word     = in_range ? rd_word_raw : '0;

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] wr_par;
  logic [NB-1:0] rd_par_calc;
  logic          par_mismatch;

  // Per-lane even parity for the write path (optionally inverted for error
  // injection) and recomputed parity of the word being read.
  always_comb begin
    wr_par      = '0;
    rd_par_calc = '0;
    for (int k = 0; k < NB; k++) begin
      wr_par[k]      = (^in_mem_write_data[8*k +: 8]) ^ in_mem_par_flip;
      rd_par_calc[k] = ^rd_word_raw[8*k +: 8];
    end
  end

  assign par_mismatch = |(rd_par_calc ^ par_q[in_mem_addr]);
  assign rd_err       = !in_range || par_mismatch;

  // Parity bits follow their data lanes; never reset, like the array.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      for (int k = 0; k < NB; k++) begin
        if (in_mem_byte_en[k]) begin
          par_q[in_mem_addr][k] <= wr_par[k];
        end
      end
    end
  end
`else
  assign rd_err = !in_range;
`endif

  // Byte-lane writes into the array; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      for (int k = 0; k < NB; k++) begin
        if (in_mem_byte_en[k]) begin
          mem_q[in_mem_addr][8*k +: 8] <= in_mem_write_data[8*k +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline: stage 1 samples the array on the accept edge
  // --------------------------------------------------------------------------
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_err_q;

  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              push_err;

  // Capture the addressed word (or zero for out-of-range) at the accept edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= rd_acc;
      if (rd_acc) begin
        s1_data_q <= rd_word;
        s1_err_q  <= rd_err;
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              s2_valid_q;
      logic [DATA_W-1:0] s2_data_q;
      logic              s2_err_q;

      // Extra output pipeline register for the two-cycle latency build.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
          s2_err_q   <= 1'b0;
        end else begin
          s2_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            s2_data_q <= s1_data_q;
            s2_err_q  <= s1_err_q;
          end
        end
      end

      assign push      = s2_valid_q;
      assign push_data = s2_data_q;
      assign push_err  = s2_err_q;
    end else begin : g_lat1
      assign push      = s1_valid_q;
      assign push_data = s1_data_q;
      assign push_err  = s1_err_q;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Response FIFO (RESP_DEPTH entries) and credit counter
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]     fifo_data_q [RESP_DEPTH];
  logic [RESP_DEPTH-1:0] fifo_err_q;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]      credit_q, credit_d;
  logic                  rdy_en_q;

  // Pointer/count next-state; credits cover in-flight reads plus entries.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    credit_d   = credit_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    case ({rd_acc, pop})
      2'b10:   credit_d = credit_q + CNT_ONE;
      2'b01:   credit_d = credit_q - CNT_ONE;
      default: credit_d = credit_q;
    endcase
  end

  // Control state; in-flight reads and queued responses vanish on reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      credit_q   <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      credit_q   <= credit_d;
      rdy_en_q   <= 1'b1;
    end
  end

  // FIFO payload storage; outputs are masked while empty so no reset needed.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_err_q[wr_ptr_q]  <= push_err;
    end
  end

  // Credits never exceed RESP_DEPTH, so a push always finds a free entry.
  assign out_mem_req_ready  = rdy_en_q &&
                              ((credit_q < CNT_FULL) || ((credit_q == CNT_FULL) && pop));
  assign out_mem_resp_valid = (fifo_cnt_q != '0);
  assign out_mem_data       = out_mem_resp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_mem_resp_err   = out_mem_resp_valid ? fifo_err_q[rd_ptr_q]  : 1'b0;

endmodule
`default_nettype wire

// File: doc/mem_bank_ctrl.md
Name: mem_bank_ctrl

Overview:
- Parametrised single-port data memory with byte-enabled writes and a valid/ready request channel.
- Reads return through a buffered valid/ready response channel with configurable read latency.
- Sits between the LSU and on-chip SRAM; supports back-pressure from the consumer and flags out-of-range accesses.
- Next generation of the fixed 32x1024 data memory.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8.
- DEPTH, 1024, number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH), word-address width.
- READ_LAT, 1, cycles from read accept to data available; legal values 1 or 2.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- in_mem_req_valid  in  1  request valid.
- out_mem_req_ready  out  1  request accepted when valid && ready.
- in_mem_addr  in  ADDR_W  word address.
- in_mem_re_web  in  1  1 = read, 0 = write.
- in_mem_write_data  in  DATA_W  write data.
- in_mem_byte_en  in  DATA_W/8  per-byte write enable; ignored on reads.
- out_mem_resp_valid  out  1  read response valid.
- in_mem_resp_ready  in  1  consumer accepts response.
- out_mem_data  out  DATA_W  read data; held stable while valid && !ready.
- out_mem_resp_err  out  1  error flag accompanying the response.

Behaviour:
- Reset (async assert, i_rst=1):
  - out_mem_req_ready=0, out_mem_resp_valid=0, out_mem_data=0, out_mem_resp_err=0.
  - Response FIFO emptied; credit counter=0; all in-flight reads discarded.
  - Memory array contents are not reset.
  - First edge after deassertion: ready=1.
- Accept: on the edge where in_mem_req_valid && out_mem_req_ready.
- Write:
  - Each byte lane k with byte_en[k]=1 updated at the accept edge; other lanes unchanged.
  - byte_en=0 is a legal no-op.
  - Writes produce no response and consume no credit.
- Read:
  - Array sampled at the accept edge.
  - READ_LAT=1: data enters the response FIFO at the next edge.
  - READ_LAT=2: an extra output pipeline register is inserted.
  - Best case: out_mem_resp_valid rises READ_LAT cycles after the accept edge.
- Ordering:
  - Responses are returned strictly in request order.
  - A read accepted the cycle after a write to the same address returns the new data.
  - Write-then-read in the same cycle cannot occur (one request per cycle).
- Response FIFO:
  - Depth RESP_DEPTH = READ_LAT+1.
  - Credit counter = in-flight reads + FIFO entries.
  - Counter increments on read accept and decrements on response handshake.
  - Simultaneous accept and pop leave the counter unchanged.
- Back-pressure:
  - out_mem_req_ready = (credits < RESP_DEPTH) || (credits == RESP_DEPTH && response handshake this cycle).
  - Ready applies to both reads and writes, so ready never depends on in_mem_re_web.
  - No response is ever dropped or overwritten.
- Full throughput: with in_mem_resp_ready held at 1, one read per cycle is sustained indefinitely.
- Range check:
  - Any address >= DEPTH is out of range.
  - Out-of-range write: dropped, array unchanged, no error reported.
  - Out-of-range read: response data=0, err=1.
  - In-range reads: err=0, except under the optional feature.
- Hold rule: while out_mem_resp_valid=1 && in_mem_resp_ready=0, out_mem_data and out_mem_resp_err are held stable.
- Reset mid-operation: any accepted but unreturned reads are lost; the requester must reissue them.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane and written with that lane.
  - Extra input port in_mem_par_flip (1 bit): when 1 on a write, the stored parity of every written lane is inverted (error injection).
  - On a read, any lane parity mismatch sets out_mem_resp_err=1; data is still returned unmodified.
- Undefined: no parity storage, no in_mem_par_flip port; err reflects only the range check.

Test Plan:
- Reset then write addr 5, data 0xDEADBEEF, byte_en 4'hF; read addr 5 -> after READ_LAT cycles resp_valid=1, data=0xDEADBEEF, err=0.
- Write addr 5, data 0x11223344, byte_en 4'b0101 over 0xDEADBEEF; read -> 0xDE22BE44.
- Hold in_mem_resp_ready=0 and issue 4 back-to-back reads (READ_LAT=1) -> exactly 2 accepted, then ready=0; release ready -> responses return in order with no loss, and ready reasserts in the same cycle as the first pop.
- DEPTH=1000, read addr 1010 -> data=0, err=1; write addr 1010 then read addr 1010-1024 mod check of addr 1010 region -> array unchanged (spot-read addr 0..999 intact).
- Assert i_rst asynchronously mid-cycle with 2 reads in flight -> outputs drop to 0 immediately, no stale response after release, and a subsequent read returns the pre-reset stored data.
- MEM_PARITY_EN: write addr 7 with in_mem_par_flip=1, then read addr 7 -> err=1 with data intact; rewrite with flip=0 and read -> err=0.
